cipher_iterative: RTL and testbench

//  Iterative AES encryption core (FIPS-197), forward counterpart of the combinational inverse cipher.

---
 rtl/cipher_iterative.sv | 198 +++++++++++++++++++
 tb/tb_cipher_iterative.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cipher_iterative.sv
// Iterative AES encryption core: one cipher round per clock over a single
// 128-bit state register. Round keys come from a combinational key expansion
// of the captured cipher key.
// Byte 0 of a block sits in bits [127:120]; columns are packed MSB-first.
module cipher_iterative #(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     data_in,
    input  logic [Nk*32-1:0] key,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     data_out
);
    localparam int ROUND_W = $clog2(Nr + 1);
    localparam int NW      = 4 * (Nr + 1);
    localparam logic [ROUND_W-1:0] LAST_ROUND  = ROUND_W'(Nr);
    localparam logic [ROUND_W-1:0] FIRST_ROUND = ROUND_W'(1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            else      acc = acc;
            sh = xtime(sh);
        end
        return acc;
    endfunction

    // Forward S-box: multiplicative inverse (x^254) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] p2, p4, p8, p16, p32, p64, p128, inv;
        p2   = gf_mul(x, x);
        p4   = gf_mul(p2, p2);
        p8   = gf_mul(p4, p4);
        p16  = gf_mul(p8, p8);
        p32  = gf_mul(p16, p16);
        p64  = gf_mul(p32, p32);
        p128 = gf_mul(p64, p64);
        inv  = gf_mul(gf_mul(gf_mul(p2, p4), gf_mul(p8, p16)),
                      gf_mul(gf_mul(p32, p64), p128));
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // Full key schedule; word 0 lands in the most significant slice.
    function automatic logic [NW*32-1:0] expand_key(input logic [Nk*32-1:0] k);
        logic [NW*32-1:0] w;
        logic [31:0]      prev;
        logic [31:0]      temp;
        logic [7:0]       rcon;
        w    = '0;
        rcon = 8'h01;
        for (int i = 0; i < Nk; i++) begin
            w[NW*32-1-32*i -: 32] = k[Nk*32-1-32*i -: 32];
        end
        for (int i = Nk; i < NW; i++) begin
            prev = w[NW*32-1-32*(i-1) -: 32];
            if (i % Nk == 0) begin
                temp = sub_word({prev[23:0], prev[31:24]}) ^ {rcon, 24'h000000};
                rcon = xtime(rcon);
            end else if (Nk > 6 && i % Nk == 4) begin
                temp = sub_word(prev);
            end else begin
                temp = prev;
            end
            w[NW*32-1-32*i -: 32] = w[NW*32-1-32*(i-Nk) -: 32] ^ temp;
        end
        return w;
    endfunction

    // SubBytes+ShiftRows, MixColumns unless final round, then AddRoundKey.
    function automatic logic [127:0] enc_round(input logic [127:0] s, input logic [127:0] rk,
                                               input logic last);
        logic [7:0]   t [16];
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                t[4*c+row] = sbox(s[127-8*(4*((c+row)%4)+row) -: 8]);
            end
        end
        for (int c = 0; c < 4; c++) begin
            if (last) r[127-32*c -: 32] = {t[4*c], t[4*c+1], t[4*c+2], t[4*c+3]};
            else      r[127-32*c -: 32] = mix_column({t[4*c], t[4*c+1], t[4*c+2], t[4*c+3]});
        end
        return r ^ rk;
    endfunction

    state_t               state_r, next_state_s;
    logic [ROUND_W-1:0]   round_r;
    logic [127:0]         st_r;
    logic [Nk*32-1:0]     key_r;
    logic [127:0]         data_out_r;
    logic                 out_valid_r;
    logic                 in_ready_r;
    logic [NW*32-1:0]     rk_all_s;
    logic [127:0]         rk_s;
    logic                 accept_s;

    assign accept_s  = in_valid & in_ready_r;
    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign data_out  = data_out_r;

    // Round key selection for the round currently being applied.
    always_comb begin
        rk_all_s = expand_key(key_r);
        rk_s     = rk_all_s[NW*32-1-128*int'(round_r) -: 128];
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_r <= S_IDLE;
        else       state_r <= next_state_s;
    end

    // FSM next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_IDLE:  if (accept_s) next_state_s = S_RUN;
                     else          next_state_s = S_IDLE;
            S_RUN:   if (round_r == LAST_ROUND) next_state_s = S_DONE;
                     else                       next_state_s = S_RUN;
            S_DONE:  if (out_ready) next_state_s = S_IDLE;
                     else           next_state_s = S_DONE;
            default: next_state_s = S_IDLE;
        endcase
    end

    // Datapath: capture block, iterate rounds, present and hold ciphertext.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            round_r     <= '0;
            st_r        <= '0;
            key_r       <= '0;
            data_out_r  <= '0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            in_ready_r <= (next_state_s == S_IDLE);
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        key_r   <= key;
                        st_r    <= data_in ^ key[Nk*32-1 -: 128];
                        round_r <= FIRST_ROUND;
                    end
                end
                S_RUN: begin
                    if (round_r == LAST_ROUND) begin
                        data_out_r  <= enc_round(st_r, rk_s, 1'b1);
                        out_valid_r <= 1'b1;
                        round_r     <= '0;
                    end else begin
                        st_r    <= enc_round(st_r, rk_s, 1'b0);
                        round_r <= round_r + FIRST_ROUND;
                    end
                end
                S_DONE: begin
                    if (out_ready) out_valid_r <= 1'b0;
                end
                default: begin
                    out_valid_r <= 1'b0;
                    round_r     <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cipher_iterative.sv
// Directed bench for cipher_iterative (AES-128) with a table-driven reference
// encrypt/decrypt model used for loopback and random block checks.
module tb_cipher_iterative;
    localparam int Nk = 4;
    localparam int Nr = 10;

    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT2 = 128'h3925841d02dc09fbdc118597196a0b32;

    localparam logic [2047:0] SBOX_HEX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] data_in = '0;
    logic [127:0] key = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] data_out;

    int n_vec = 0;
    int n_miss = 0;
    int cyc = 0;
    int accept_cyc = 0;
    logic [7:0] sbox_t [256];
    logic [7:0] inv_t [256];

    cipher_iterative #(.Nk(Nk), .Nr(Nr)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .key(key), .out_valid(out_valid), .out_ready(out_ready),
        .data_out(data_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Round key r, byte i lives at ks[1407 - 128*r - 8*i -: 8].
    function automatic logic [1407:0] ref_expand(input logic [127:0] k);
        logic [31:0]   w [44];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1407:0] o;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]], sbox_t[t[31:24]]} ^ {rc, 24'h000000};
                rc = mul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 44; i++) o[1407-32*i -: 32] = w[i];
        return o;
    endfunction

    function automatic logic [127:0] ref_enc(input logic [127:0] pt, input logic [127:0] k);
        logic [1407:0] ks;
        logic [7:0]    s [16];
        logic [7:0]    t [16];
        logic [127:0]  o;
        ks = ref_expand(k);
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ ks[1407-8*i -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int c = 0; c < 4; c++)
                for (int j = 0; j < 4; j++) t[4*c+j] = sbox_t[s[4*((c+j)%4)+j]];
            for (int c = 0; c < 4; c++) begin
                if (r < 10) begin
                    s[4*c]   = mul(t[4*c], 8'h02) ^ mul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ mul(t[4*c+1], 8'h02) ^ mul(t[4*c+2], 8'h03) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ mul(t[4*c+2], 8'h02) ^ mul(t[4*c+3], 8'h03);
                    s[4*c+3] = mul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ mul(t[4*c+3], 8'h02);
                end else begin
                    for (int j = 0; j < 4; j++) s[4*c+j] = t[4*c+j];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ ks[1407-128*r-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    function automatic logic [127:0] ref_dec(input logic [127:0] ct, input logic [127:0] k);
        logic [1407:0] ks;
        logic [7:0]    s [16];
        logic [7:0]    t [16];
        logic [127:0]  o;
        ks = ref_expand(k);
        for (int i = 0; i < 16; i++) s[i] = ct[127-8*i -: 8] ^ ks[1407-1280-8*i -: 8];
        for (int r = 9; r >= 0; r--) begin
            for (int c = 0; c < 4; c++)
                for (int j = 0; j < 4; j++) t[4*c+j] = inv_t[s[4*((c-j+4)%4)+j]];
            for (int i = 0; i < 16; i++) t[i] = t[i] ^ ks[1407-128*r-8*i -: 8];
            for (int c = 0; c < 4; c++) begin
                if (r > 0) begin
                    s[4*c]   = mul(t[4*c], 8'h0e) ^ mul(t[4*c+1], 8'h0b) ^ mul(t[4*c+2], 8'h0d) ^ mul(t[4*c+3], 8'h09);
                    s[4*c+1] = mul(t[4*c], 8'h09) ^ mul(t[4*c+1], 8'h0e) ^ mul(t[4*c+2], 8'h0b) ^ mul(t[4*c+3], 8'h0d);
                    s[4*c+2] = mul(t[4*c], 8'h0d) ^ mul(t[4*c+1], 8'h09) ^ mul(t[4*c+2], 8'h0e) ^ mul(t[4*c+3], 8'h0b);
                    s[4*c+3] = mul(t[4*c], 8'h0b) ^ mul(t[4*c+1], 8'h0d) ^ mul(t[4*c+2], 8'h09) ^ mul(t[4*c+3], 8'h0e);
                end else begin
                    for (int j = 0; j < 4; j++) s[4*c+j] = t[4*c+j];
                end
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    // Offer a block and return just after the accepting edge.
    task automatic send(input logic [127:0] pt, input logic [127:0] k);
        int guard;
        guard = 0;
        data_in  = pt;
        key      = k;
        in_valid = 1'b1;
        while (!in_ready && guard < 100) begin
            tick();
            guard++;
        end
        if (!in_ready) chk("accept_timeout", 128'(in_ready), 128'd1);
        tick();
        accept_cyc = cyc;
        in_valid   = 1'b0;
    endtask

    // Count edges from the accepting edge until out_valid rises.
    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
        chk("out_valid_rise", 128'(out_valid), 128'd1);
    endtask

    initial begin
        logic [2047:0] sb_v;
        logic [127:0]  pt, k;
        int            lat;
        int            prev_cyc;

        sb_v = SBOX_HEX;
        for (int i = 0; i < 256; i++) begin
            sbox_t[i] = sb_v[2047-8*i -: 8];
            inv_t[sbox_t[i]] = 8'(i);
        end
        chk("model_c1", ref_enc(PT1, K1), CT1);
        chk("model_b",  ref_enc(PT2, K2), CT2);

        // Reset state
        #2 reset = 1'b1;
        tick();
        tick();
        chk("rst_in_ready",  128'(in_ready),  128'd1);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_data_out",  data_out,        128'd0);
        reset = 1'b0;
        tick();

        // C.1 vector, latency, loopback through the inverse model
        send(PT1, K1);
        chk("run_in_ready", 128'(in_ready), 128'd0);
        wait_out(lat);
        chk("c1_latency", 128'(lat), 128'd10);
        chk("c1_ct", data_out, CT1);
        chk("c1_loopback", ref_dec(data_out, K1), PT1);

        // Backpressure: hold result for 20 cycles
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("bp_out_valid", 128'(out_valid), 128'd1);
            chk("bp_data_out",  data_out,        CT1);
            chk("bp_in_ready",  128'(in_ready),  128'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("rel_in_ready",  128'(in_ready),  128'd1);
        chk("rel_out_valid", 128'(out_valid), 128'd0);
        chk("rel_data_hold", data_out,        CT1);

        // Stray out_ready while idle changes nothing
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        chk("idle_out_valid", 128'(out_valid), 128'd0);
        chk("idle_data_hold", data_out,        CT1);

        // App.B vector with a different block held on the inputs while busy
        send(PT2, K2);
        data_in  = PT1;
        key      = K1;
        in_valid = 1'b1;
        wait_out(lat);
        chk("b_latency", 128'(lat), 128'd10);
        chk("b_ct", data_out, CT2);
        chk("busy_in_ready", 128'(in_ready), 128'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("held_in_ready", 128'(in_ready), 128'd1);
        tick();
        in_valid = 1'b0;
        chk("held_accepted", 128'(in_ready), 128'd0);
        wait_out(lat);
        chk("held_latency", 128'(lat), 128'd10);
        chk("held_ct", data_out, CT1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset in the middle of a block (round 5 pending)
        send(PT2, K2);
        repeat (4) tick();
        reset = 1'b1;
        #1;
        chk("abort_out_valid", 128'(out_valid), 128'd0);
        chk("abort_data_out",  data_out,        128'd0);
        chk("abort_in_ready",  128'(in_ready),  128'd1);
        tick();
        reset = 1'b0;
        tick();
        send(PT1, K1);
        wait_out(lat);
        chk("post_rst_latency", 128'(lat), 128'd10);
        chk("post_rst_ct", data_out, CT1);

        // Back-to-back random blocks with out_ready tied high
        out_ready = 1'b1;
        tick();
        prev_cyc = 0;
        for (int b = 0; b < 8; b++) begin
            pt = {$urandom(), $urandom(), $urandom(), $urandom()};
            k  = {$urandom(), $urandom(), $urandom(), $urandom()};
            send(pt, k);
            if (b > 0) chk("b2b_period", 128'(accept_cyc - prev_cyc), 128'd12);
            prev_cyc = accept_cyc;
            wait_out(lat);
            chk("b2b_ct", data_out, ref_enc(pt, k));
            chk("b2b_loopback", ref_dec(data_out, k), pt);
        end
        out_ready = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
